// File: rtl/day_14_rr_arbiter.sv
// day_14_rr_arbiter: round-robin arbiter with hold limit driving a one-hot AND-OR N:1 bit mux
module day_14_rr_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 8,
  parameter int IDX_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [NUM_REQ-1:0] x_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic               gnt_valid_o,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic               y_o
);
  localparam int HW = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] win;
  logic [HW-1:0] hold;
  logic [NUM_REQ-1:0] cand;
  logic found;
  logic own_req;
  logic at_limit;
  logic move;
  always_comb begin
    cand = req_i & ~gnt_o;
    own_req = |(req_i & gnt_o);
    found = 1'b0;
    win = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && cand[(int'(ptr) + i) % NUM_REQ]) begin
        found = 1'b1;
        win = IDX_W'((int'(ptr) + i) % NUM_REQ);
      end
    end
    at_limit = (MAX_HOLD != 0) && (int'(hold) == MAX_HOLD - 1);
    move = (state == IDLE) || !own_req || (at_limit && found);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gnt_o <= '0;
      gnt_valid_o <= 1'b0;
      gnt_idx_o <= '0;
      ptr <= '0;
      hold <= '0;
      state <= IDLE;
    end else if (move) begin
      gnt_o <= found ? (NUM_REQ'(1) << win) : '0;
      gnt_valid_o <= found;
      gnt_idx_o <= found ? win : '0;
      ptr <= !found ? ptr : (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
      hold <= '0;
      state <= found ? BUSY : IDLE;
    end else if (int'(hold) < MAX_HOLD - 1) begin
      hold <= hold + 1'b1;
    end
  end
  assign y_o = |(x_i & gnt_o);
endmodule
